// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: request, FPU unit and writeback bundle for the FP issue controller
interface fpu_issue_ctrl_if #(
    parameter int NUNIT = 4,
    parameter int RD_W  = 5
);
    logic                     req_valid;
    logic                     req_ready;
    logic [$clog2(NUNIT)-1:0] req_unit;
    logic [RD_W-1:0]          req_rd;
    logic [31:0]              req_a;
    logic [31:0]              req_b;
    logic [NUNIT-1:0]         unit_valid;
    logic [31:0]              unit_x;
    logic [31:0]              unit_y;
    logic [NUNIT-1:0]         unit_out_valid;
    logic [NUNIT*32-1:0]      unit_result;
    logic                     wb_valid;
    logic [RD_W-1:0]          wb_rd;
    logic [31:0]              wb_data;

    modport master (
        output req_valid, req_unit, req_rd, req_a, req_b, unit_out_valid, unit_result,
        input  req_ready, unit_valid, unit_x, unit_y, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  req_valid, req_unit, req_rd, req_a, req_b, unit_out_valid, unit_result,
        output req_ready, unit_valid, unit_x, unit_y, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues FP ops to fixed-latency units, reserves return slots, registers writeback; FPU_ISSUE_PERF_EN adds perf counters
module fpu_issue_ctrl #(
    parameter int NUNIT   = 4,
    parameter int RD_W    = 5,
    parameter int LAT0    = 1,
    parameter int LAT1    = 1,
    parameter int LAT2    = 3,
    parameter int LAT3    = 4,
    parameter int MAX_LAT = 4
) (
    input  logic           sys_clk,
    input  logic           rst,
    fpu_issue_ctrl_if.slave bus,
    output logic           err
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0]    perf_issue,
    output logic [31:0]    perf_stall
`endif
);
    localparam int UW = $clog2(NUNIT);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic [MAX_LAT-1:0] rv;
    logic [UW-1:0]      ru [MAX_LAT];
    logic [RD_W-1:0]    rr [MAX_LAT];
    logic [LW-1:0]      mcnt;
    logic [LW-1:0]      lat;
    logic [MAX_LAT:0]   busy;
    logic [NUNIT-1:0]   expect_ov;
    logic               issue;
    logic               missing;
    logic               extra;

    // Issue decision, unit strobes and per-cycle return check
    always_comb begin
        lat = (bus.req_unit == UW'(0)) ? LW'(LAT0) :
              (bus.req_unit == UW'(1)) ? LW'(LAT1) :
              (bus.req_unit == UW'(2)) ? LW'(LAT2) : LW'(LAT3);
        busy = {1'b0, rv};
        bus.req_ready = ~busy[lat];
        issue = bus.req_valid & bus.req_ready & ~rst;
        bus.unit_valid = issue ? NUNIT'(1) << bus.req_unit : '0;
        bus.unit_x = bus.req_a;
        bus.unit_y = bus.req_b;
        expect_ov = rv[0] ? NUNIT'(1) << ru[0] : '0;
        missing = rv[0] & ~bus.unit_out_valid[ru[0]];
        extra = (mcnt == '0) & |(bus.unit_out_valid & ~expect_ov);
    end

    // Reservation shift register; a new issue overrides the shift into its slot
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rv <= '0;
            for (int i = 0; i < MAX_LAT; i++) begin
                ru[i] <= '0;
                rr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_LAT - 1; i++) begin
                rv[i] <= rv[i+1];
                ru[i] <= ru[i+1];
                rr[i] <= rr[i+1];
            end
            rv[MAX_LAT-1] <= 1'b0;
            if (issue) begin
                rv[lat - LW'(1)] <= 1'b1;
                ru[lat - LW'(1)] <= bus.req_unit;
                rr[lat - LW'(1)] <= bus.req_rd;
            end
        end
    end

    // Registered writeback from the unit scheduled to return this cycle
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
        end else begin
            bus.wb_valid <= rv[0];
            if (rv[0]) begin
                bus.wb_rd   <= rr[0];
                bus.wb_data <= bus.unit_result[{ru[0], 5'd0} +: 32];
            end
        end
    end

    // Sticky protocol error; stray returns are masked for MAX_LAT cycles after reset
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err  <= 1'b0;
            mcnt <= LW'(MAX_LAT);
        end else begin
            err <= err | missing | extra;
            if (mcnt != '0) mcnt <= mcnt - LW'(1);
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    // Saturating counts of issue cycles and stalled request cycles
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (issue && perf_issue != '1) perf_issue <= perf_issue + 32'd1;
            if (bus.req_valid && !bus.req_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for fpu_issue_ctrl with a four-unit FPU model
module tb_fpu_issue_ctrl;
    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic [3:0] suppress = '0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } wb_t;

    wb_t q[$];
    wb_t e_mon;

    fpu_issue_ctrl_if #(.NUNIT(4), .RD_W(5)) bus ();

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_stall;
`endif

    fpu_issue_ctrl dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(bus),
        .err(err)
`ifdef FPU_ISSUE_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 1 : (u == 2) ? 3 : 4;
    endfunction

    // Unit 0 fabs, unit 1 fneg, unit 2 xor, unit 3 and
    function automatic logic [31:0] fn(input int u, input logic [31:0] a, input logic [31:0] b);
        return (u == 0) ? {1'b0, a[30:0]} : (u == 1) ? {~a[31], a[30:0]} : (u == 2) ? (a ^ b) : (a & b);
    endfunction

    logic [3:0]  pv [4];
    logic [31:0] pd [4][4];

    initial begin
        for (int u = 0; u < 4; u++) begin
            pv[u] = '0;
            for (int k = 0; k < 4; k++) pd[u][k] = '0;
        end
    end

    // Fixed-latency unit pipelines; not reset so stale returns survive a controller reset
    always @(posedge sys_clk) begin
        for (int u = 0; u < 4; u++) begin
            pv[u] <= {pv[u][2:0], bus.unit_valid[u]};
            pd[u][0] <= fn(u, bus.unit_x, bus.unit_y);
            for (int k = 1; k < 4; k++) pd[u][k] <= pd[u][k-1];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_unit
        assign bus.unit_out_valid[g] = pv[g][lat_of(g)-1] & ~suppress[g];
        assign bus.unit_result[32*g +: 32] = pd[g][lat_of(g)-1];
    end

    // Writeback monitor: pops the scoreboard on every wb_valid
    always @(negedge sys_clk) begin
        if (bus.wb_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h at cycle %0d, required no writeback", bus.wb_rd, bus.wb_data, cyc);
            end else begin
                e_mon = q.pop_front();
                if (bus.wb_rd !== e_mon.rd || bus.wb_data !== e_mon.data || cyc != e_mon.due) begin
                    fails++;
                    $display("FAIL wb_check: got rd=%0d data=%h cycle=%0d, required rd=%0d data=%h cycle=%0d",
                             bus.wb_rd, bus.wb_data, cyc, e_mon.rd, e_mon.data, e_mon.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            tests++;
            fails++;
            e_mon = q.pop_front();
            $display("FAIL wb_missing: got no writeback at cycle %0d, required rd=%0d data=%h", cyc, e_mon.rd, e_mon.data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, input logic wb, input logic [31:0] d);
        @(negedge sys_clk);
        bus.req_valid = 1'b1;
        bus.req_unit  = 2'(u);
        bus.req_rd    = rd;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(rdy));
        chk("unit_valid", 32'(bus.unit_valid), rdy ? (32'd1 << u) : 32'd0);
        if (rdy && wb) q.push_back('{rd, d, cyc + lat_of(u) + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        bus.req_valid = 1'b1;
        bus.req_unit  = 2'd3;
        bus.req_rd    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_unit_valid", 32'(bus.unit_valid), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        idle(10);
        #1;
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_unit_valid", 32'(bus.unit_valid), 32'd0);
        chk("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("idle_err", 32'(err), 32'd0);

        drive(0, 5'd5, 32'hC0400000, 32'h0, 1'b1, 1'b1, 32'h40400000);
        idle(4);

        drive(0, 5'd1, 32'hBF800000, 32'h0, 1'b1, 1'b1, 32'h3F800000);
        drive(0, 5'd2, 32'h3F000000, 32'h0, 1'b1, 1'b1, 32'h3F000000);
        drive(0, 5'd3, 32'hC1200000, 32'h0, 1'b1, 1'b1, 32'h41200000);
        drive(0, 5'd4, 32'h80000001, 32'h0, 1'b1, 1'b1, 32'h00000001);
        idle(4);

        drive(3, 5'd7, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 1'b1, 32'h0F000F00);
        drive(2, 5'd9, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b1, 32'hEDCB5678);
        drive(2, 5'd9, 32'h12345678, 32'hFFFF0000, 1'b1, 1'b1, 32'hEDCB5678);
        idle(8);

        drive(2, 5'd10, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 32'hFFFFFFFF);
        idle(1);
        drive(0, 5'd11, 32'h80000000, 32'h0, 1'b0, 1'b1, 32'h00000000);
        drive(0, 5'd11, 32'h80000000, 32'h0, 1'b1, 1'b1, 32'h00000000);
        drive(1, 5'd12, 32'h3F800000, 32'h0, 1'b1, 1'b1, 32'hBF800000);
        idle(6);

        suppress = 4'b0001;
        drive(0, 5'd13, 32'hC0000000, 32'h0, 1'b1, 1'b1, 32'h40000000);
        chk("err_before_return", 32'(err), 32'd0);
        idle(1);
        #1;
        chk("err_at_return", 32'(err), 32'd0);
        idle(1);
        #1;
        chk("err_after_return", 32'(err), 32'd1);
        suppress = 4'b0000;
        idle(3);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        idle(2);

        drive(3, 5'd14, 32'h01234567, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
        idle(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_unit_valid", 32'(bus.unit_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            #1;
            chk("stale_err", 32'(err), 32'd0);
        end
        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
